// File: rtl/inst_cache_dm_if.sv
// Fetch-side and instruction-memory-side signals of the direct-mapped instruction cache.
// The slave modport is the cache; the master modport is the CPU fetch stage plus the memory.
interface inst_cache_dm_if;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         FLUSH;
    logic         INST_MEM_READ;
    logic [27:0]  INST_MEM_ADDRESS;
    logic [127:0] INST_MEM_READDATA;
    logic         INST_MEM_BUSYWAIT;

    modport slave (
        input  PC, FLUSH, INST_MEM_READDATA, INST_MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, INST_MEM_READ, INST_MEM_ADDRESS
    );

    modport master (
        output PC, FLUSH, INST_MEM_READDATA, INST_MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, INST_MEM_READ, INST_MEM_ADDRESS
    );
endinterface

// File: rtl/inst_cache_dm.sv
// Direct-mapped read-only instruction cache, 128-bit lines of four instructions.
// Hits answer combinationally; misses stall the CPU while the whole block is fetched.
module inst_cache_dm #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 25
) (
    input  logic          CLK,
    input  logic          RESET,
    inst_cache_dm_if.slave bus
);
    localparam int          LINES    = 1 << INDEX_BITS;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  MEM_READ = 2'd1;
    localparam logic [1:0]  UPDATE   = 2'd2;

    logic [1:0]          state_reg;
    logic [LINES-1:0]    valid_reg;
    logic [27:0]         miss_reg;
    logic                entry_reg;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [127:0]        data_mem [LINES];

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  hit;
    logic                  fill;
    logic [31:0]           line_words [4];
    logic                  unused_pc_bits;

    assign offset         = bus.PC[3:2];
    assign index          = bus.PC[3+INDEX_BITS:4];
    assign tag            = bus.PC[31:4+INDEX_BITS];
    assign unused_pc_bits = &{1'b0, bus.PC[1:0]};
    assign miss_index     = miss_reg[INDEX_BITS-1:0];
    assign miss_tag       = miss_reg[27:INDEX_BITS];

    assign hit = valid_reg[index] && (tag_mem[index] == tag);

    // The memory's handshake is not trusted on the first MEM_READ cycle.
    assign fill = (state_reg == MEM_READ) && !entry_reg && !bus.INST_MEM_BUSYWAIT;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            assign line_words[gi] = data_mem[index][32*gi +: 32];
        end
    endgenerate

    assign bus.INSTRUCTION      = hit ? line_words[offset] : NOP;
    assign bus.BUSYWAIT         = RESET && ((state_reg != IDLE) || !hit);
    assign bus.INST_MEM_READ    = (state_reg == MEM_READ);
    assign bus.INST_MEM_ADDRESS = miss_reg;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= IDLE;
            valid_reg <= '0;
            miss_reg  <= '0;
            entry_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.FLUSH) begin
                        valid_reg <= '0;
                    end else if (!hit) begin
                        miss_reg  <= {tag, index};
                        entry_reg <= 1'b1;
                        state_reg <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    entry_reg <= 1'b0;
                    if (fill) begin
                        valid_reg[miss_index] <= 1'b1;
                        state_reg             <= UPDATE;
                    end
                end
                UPDATE:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Fill is gated by state, so an abandoned transaction can never land here.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_mem[miss_index]  <= miss_tag;
            data_mem[miss_index] <= bus.INST_MEM_READDATA;
        end
    end
endmodule
